// File: rtl/butterfly_pipe.sv
// -----------------------------------------------------------------------------
// butterfly_pipe
// Pipelined radix-2 DIT butterfly with valid/ready handshake.
//   out0 = A + B*W',  out1 = A - B*W',  W' = inverse ? conj(W) : W
// Optional divide-by-two (scale), round-half-up rescale, saturation to the
// component range, per-result overflow flag and a sticky overflow flag.
//
// Packed complex word: real = [WIDTH-1:HALF], imag = [HALF-1:0], signed,
// FRAC fractional bits per component.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake for a, b, w, inverse, scale
//   a, b, w           packed complex operands (w = twiddle)
//   inverse           use conj(W) for this transaction
//   scale             halve both results of this transaction
//   out_valid/out_ready output handshake for out0, out1, ovf_now
//   out0, out1        butterfly results
//   ovf_now           this result saturated in at least one component
//   clr_ovf           clears ovf_sticky (a simultaneous set wins)
//   ovf_sticky        an accepted result has saturated since last clear
//
// Pipeline: s1 (operand regs) -> s2 (products) -> s3 (full-precision sums)
// -> output regs (rescale + saturate). One shared enable stalls everything.
// -----------------------------------------------------------------------------
module butterfly_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = WIDTH / 2 - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] w,
  input  logic             inverse,
  input  logic             scale,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             ovf_now,
  input  logic             clr_ovf,
  output logic             ovf_sticky
);

  localparam int HALF = WIDTH / 2;
  localparam int PW   = 2 * HALF;      // product width; pr/pi carry one more bit
  localparam int SW   = 2 * HALF + 2;  // sum width

  localparam logic [HALF-1:0]      H_MIN   = {1'b1, {(HALF-1){1'b0}}};
  localparam logic [HALF-1:0]      H_MAX   = ~H_MIN;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-HALF+1){1'b0}}, {(HALF-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic signed [SW-1:0] ONE     = {{(SW-1){1'b0}}, 1'b1};

  // Sign-extend one component to the product width.
  function automatic logic signed [PW:0] sext_p(input logic [HALF-1:0] x);
    return {{(PW+1-HALF){x[HALF-1]}}, x};
  endfunction

  // Sign-extend one component to the sum width.
  function automatic logic signed [SW-1:0] sext_s(input logic [HALF-1:0] x);
    return {{(SW-HALF){x[HALF-1]}}, x};
  endfunction

  // Round half up, arithmetic shift, clamp; returns {clamped, component}.
  function automatic logic [HALF:0] rescale_sat(input logic signed [SW-1:0] sum,
                                                input logic              halve);
    logic signed [SW-1:0] biased;
    logic signed [SW-1:0] shifted;
    logic [HALF:0]        res;
    if (halve) begin
      biased  = sum + (ONE <<< (FRAC + 1 - 1));
      shifted = biased >>> (FRAC + 1);
    end else begin
      biased  = sum + (ONE <<< (FRAC - 1));
      shifted = biased >>> FRAC;
    end
    if (shifted > SAT_MAX) begin
      res = {1'b1, SAT_MAX[HALF-1:0]};
    end else if (shifted < SAT_MIN) begin
      res = {1'b1, SAT_MIN[HALF-1:0]};
    end else begin
      res = {1'b0, shifted[HALF-1:0]};
    end
    return res;
  endfunction

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- stage 1: operand registers ----------------
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b, s1_w;
  logic             s1_inv, s1_scale;

  // ---------------- stage 2: products ----------------
  logic             s2_valid;
  logic [WIDTH-1:0] s2_a;
  logic             s2_scale;
  logic signed [PW:0] s2_pr, s2_pi;

  // ---------------- stage 3: full-precision sums ----------------
  logic             s3_valid;
  logic             s3_scale;
  logic signed [SW-1:0] s3_s0r, s3_s0i, s3_s1r, s3_s1i;

  // Twiddle imaginary part after optional conjugation; -MIN saturates to MAX.
  logic [HALF-1:0] w_im;
  always_comb begin
    w_im = s1_w[HALF-1:0];
    if (s1_inv) begin
      if (s1_w[HALF-1:0] == H_MIN) begin
        w_im = H_MAX;
      end else begin
        w_im = ~s1_w[HALF-1:0] + {{(HALF-1){1'b0}}, 1'b1};
      end
    end else begin
      w_im = s1_w[HALF-1:0];
    end
  end

  logic signed [PW:0] p_rr, p_ii, p_ri, p_ir, pr_c, pi_c;
  assign p_rr = sext_p(s1_b[WIDTH-1:HALF]) * sext_p(s1_w[WIDTH-1:HALF]);
  assign p_ii = sext_p(s1_b[HALF-1:0])     * sext_p(w_im);
  assign p_ri = sext_p(s1_b[WIDTH-1:HALF]) * sext_p(w_im);
  assign p_ir = sext_p(s1_b[HALF-1:0])     * sext_p(s1_w[WIDTH-1:HALF]);
  assign pr_c = p_rr - p_ii;
  assign pi_c = p_ri + p_ir;

  // A aligned to the product binary point, products extended to sum width.
  logic signed [SW-1:0] sa_r, sa_i, pr_s, pi_s;
  assign sa_r = sext_s(s2_a[WIDTH-1:HALF]) <<< FRAC;
  assign sa_i = sext_s(s2_a[HALF-1:0])     <<< FRAC;
  assign pr_s = {{(SW-PW-1){s2_pr[PW]}}, s2_pr};
  assign pi_s = {{(SW-PW-1){s2_pi[PW]}}, s2_pi};

  logic [HALF:0] r0r, r0i, r1r, r1i;
  assign r0r = rescale_sat(s3_s0r, s3_scale);
  assign r0i = rescale_sat(s3_s0i, s3_scale);
  assign r1r = rescale_sat(s3_s1r, s3_scale);
  assign r1i = rescale_sat(s3_s1i, s3_scale);

  // Valid bits for all stages; cleared by reset, advance only when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      out_valid <= s3_valid;
    end
  end

  // Pipeline data registers; bubbles carry don't-care data.
  always_ff @(posedge clk) begin
    if (en) begin
      s1_a     <= a;
      s1_b     <= b;
      s1_w     <= w;
      s1_inv   <= inverse;
      s1_scale <= scale;
      s2_a     <= s1_a;
      s2_scale <= s1_scale;
      s2_pr    <= pr_c;
      s2_pi    <= pi_c;
      s3_scale <= s2_scale;
      s3_s0r   <= sa_r + pr_s;
      s3_s0i   <= sa_i + pi_s;
      s3_s1r   <= sa_r - pr_s;
      s3_s1i   <= sa_i - pi_s;
    end
  end

  // Result registers; loaded only with valid stage-3 data.
  always_ff @(posedge clk) begin
    if (rst) begin
      out0    <= {WIDTH{1'b0}};
      out1    <= {WIDTH{1'b0}};
      ovf_now <= 1'b0;
    end else if (en && s3_valid) begin
      out0    <= {r0r[HALF-1:0], r0i[HALF-1:0]};
      out1    <= {r1r[HALF-1:0], r1i[HALF-1:0]};
      ovf_now <= r0r[HALF] | r0i[HALF] | r1r[HALF] | r1i[HALF];
    end
  end

  // Sticky overflow: set on an accepted saturated result, set beats clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_sticky <= 1'b0;
    end else if (out_valid && out_ready && ovf_now) begin
      ovf_sticky <= 1'b1;
    end else if (clr_ovf) begin
      ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_butterfly_pipe.sv
// -----------------------------------------------------------------------------
// tb_butterfly_pipe
// Scoreboard bench for butterfly_pipe (WIDTH=32, Q1.15). The driver pushes the
// expected result when a transfer is accepted; the monitor pops and compares
// whenever the DUT hands a result downstream. Inputs change #1 after the
// rising edge; both processes sample on the falling edge.
// -----------------------------------------------------------------------------
module tb_butterfly_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b, w;
  logic        inverse, scale;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out0, out1;
  logic        ovf_now;
  logic        clr_ovf;
  logic        ovf_sticky;

  butterfly_pipe #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .w(w), .inverse(inverse), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .out0(out0), .out1(out1), .ovf_now(ovf_now),
    .clr_ovf(clr_ovf), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] o0;
    logic [31:0] o1;
    logic        ov;
    logic        lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  int stall_from = -1;
  int stall_to   = -1;

  // Downstream back-pressure window, expressed in cycle numbers.
  always @(posedge clk) begin
    #1;
    out_ready = !(cyc >= stall_from && cyc < stall_to);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Golden arithmetic for one component: round half up, shift, clamp.
  function automatic logic [16:0] gsat(input longint s, input int sh);
    longint r;
    r = (s + (64'sd1 <<< (sh - 1))) >>> sh;
    if (r > 32767)       return {1'b1, 16'h7FFF};
    else if (r < -32768) return {1'b1, 16'h8000};
    else                 return {1'b0, r[15:0]};
  endfunction

  // Golden butterfly; returns {ovf, out0, out1}.
  function automatic logic [64:0] model(input logic [31:0] ma, mb, mw,
                                        input logic inv, sc);
    longint ar, ai, br, bi, wr, wi, pr, pi;
    logic [16:0] c0r, c0i, c1r, c1i;
    int sh;
    ar = longint'($signed(ma[31:16])); ai = longint'($signed(ma[15:0]));
    br = longint'($signed(mb[31:16])); bi = longint'($signed(mb[15:0]));
    wr = longint'($signed(mw[31:16])); wi = longint'($signed(mw[15:0]));
    if (inv) wi = (wi == -32768) ? 32767 : -wi;
    pr = br * wr - bi * wi;
    pi = br * wi + bi * wr;
    sh = sc ? 16 : 15;
    c0r = gsat(ar * 32768 + pr, sh);
    c0i = gsat(ai * 32768 + pi, sh);
    c1r = gsat(ar * 32768 - pr, sh);
    c1i = gsat(ai * 32768 - pi, sh);
    return {c0r[16] | c0i[16] | c1r[16] | c1i[16],
            c0r[15:0], c0i[15:0], c1r[15:0], c1i[15:0]};
  endfunction

  // Monitor: handshake sanity, hold-during-stall, scoreboard compare.
  logic        held = 1'b0;
  logic [31:0] prev0, prev1;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (held) begin
        chk("hold_out0", out0, prev0);
        chk("hold_out1", out1, prev1);
      end
      held  = out_valid && !out_ready;
      prev0 = out0;
      prev1 = out1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got out0=%h out1=%h, expected no result", out0, out1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out0", out0, e.o0);
          chk("out1", out1, e.o1);
          chk("ovf_now", ovf_now, e.ov);
          if (e.lat) chk("latency", cyc - e.acc, 3);
        end
      end
    end
  end

  // Present one transaction (caller sits #1 after a rising edge).
  task automatic send(input logic [31:0] ia, ib, iw, input logic iinv, isc,
                      input logic [31:0] e0, e1, input logic eov,
                      input logic lat, input logic push);
    int waited;
    a = ia; b = ib; w = iw; inverse = iinv; scale = isc; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 for %0d cycles, expected 1", waited);
    end else if (push) begin
      sb.push_back('{e0, e1, eov, lat, cyc + 1});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [64:0] g;
    logic [31:0] ra, rb, rw;
    logic        rinv, rsc;
    int          t0, n;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; w = '0;
    inverse = 1'b0; scale = 1'b0; clr_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ovf_now", ovf_now, 1'b0);
    chk("rst_ovf_sticky", ovf_sticky, 1'b0);
    chk("rst_out0", out0, 32'h0);
    chk("rst_out1", out1, 32'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic real product with latency check.
    send(32'h4000_0000, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 1'b0,
         32'h6000_0000, 32'h2000_0000, 1'b0, 1'b1, 1'b1);
    idle(5);
    // Imaginary twiddle, forward and inverse; then conj of -0x8000.
    send(32'h4000_0000, 32'h2000_0000, 32'h0000_7FFF, 1'b0, 1'b0,
         32'h4000_2000, 32'h4000_E000, 1'b0, 1'b0, 1'b1);
    send(32'h4000_0000, 32'h2000_0000, 32'h0000_7FFF, 1'b1, 1'b0,
         32'h4000_E000, 32'h4000_2000, 1'b0, 1'b0, 1'b1);
    send(32'h0000_0000, 32'h4000_0000, 32'h0000_8000, 1'b1, 1'b0,
         32'h0000_4000, 32'h0000_C001, 1'b0, 1'b0, 1'b1);
    idle(6);
    chk("sticky_clear_initially", ovf_sticky, 1'b0);

    // Saturation and sticky flag.
    send(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 1'b0,
         32'h7FFF_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b1);
    idle(6);
    chk("sticky_set", ovf_sticky, 1'b1);
    idle(3);
    chk("sticky_held", ovf_sticky, 1'b1);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("sticky_cleared", ovf_sticky, 1'b0);

    // Same operands with scaling: no saturation.
    send(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 1'b1,
         32'h7FFF_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    idle(6);
    chk("sticky_after_scaled", ovf_sticky, 1'b0);

    // Set beats a simultaneous clear.
    clr_ovf = 1'b1;
    send(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 1'b0,
         32'h7FFF_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b1);
    idle(3);
    chk("ovf_valid_at_k3", out_valid, 1'b1);
    idle(1);
    chk("sticky_set_wins", ovf_sticky, 1'b1);
    idle(1);
    chk("sticky_clr_after", ovf_sticky, 1'b0);
    clr_ovf = 1'b0;
    idle(4);

    // Eight back-to-back with a five-cycle downstream stall mid-stream.
    stall_from = cyc + 4;
    stall_to   = stall_from + 5;
    for (int k = 1; k <= 8; k++) begin
      logic [15:0] ar;
      ar = 16'(k * 256);
      send({ar, 16'h0000}, 32'h2000_0000, 32'h7FFF_0000, 1'b0, 1'b0,
           {ar + 16'h2000, 16'h0000}, {ar - 16'h2000, 16'h0000}, 1'b0, 1'b0, 1'b1);
    end
    idle(14);
    chk("stall_all_drained", sb.size(), 0);

    // Reset with three transactions in flight.
    send(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 1'b0,
         32'h7FFF_0000, 32'h0001_0000, 1'b1, 1'b0, 1'b1);
    idle(6);
    chk("sticky_before_rst", ovf_sticky, 1'b1);
    for (int k = 0; k < 3; k++) begin
      send(32'h1234_5678, 32'h7FFF_7FFF, 32'h7FFF_8000, 1'b0, 1'b0,
           32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_ovf_sticky", ovf_sticky, 1'b0);
    rst = 1'b0;
    idle(8);

    // Full-rate pseudo-random stream against the golden model.
    t0 = cyc;
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rw = $urandom;
      rinv = 1'($urandom_range(0, 1));
      rsc  = 1'($urandom_range(0, 1));
      if (i % 4 == 0) begin
        rw[15:0] = 16'h8000;
        rinv = 1'b1;
      end
      if (i % 7 == 0) begin
        ra = 32'h8000_8000; rb = 32'h8000_8000; rw[31:16] = 16'h8000;
      end
      g = model(ra, rb, rw, rinv, rsc);
      send(ra, rb, rw, rinv, rsc, g[63:32], g[31:0], g[64], 1'b0, 1'b1);
    end
    chk("throughput_cycles", cyc - t0, 40);
    in_valid = 1'b0;

    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("final_drain", sb.size(), 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
